qdr_cmd_buffer: RTL and testbench

- Upstream request stage feeding the QDR sniffer's slave port (slave_addr/strb/data/be in; slave_ack, slave_rd_data, slave_rd_dvld out).
- Queues user write/read commands in a FIFO and issues them one at a time, honouring slave_ack and phy_rdy.
- Tracks outstanding reads and returns read data to user logic.
- Runs entirely in the qdr_clk domain.

---
 rtl/qdr_cmd_buffer_if.sv | 52 +++++
 rtl/qdr_cmd_buffer.sv | 151 +++++++++++++++
 tb/tb_qdr_cmd_buffer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qdr_cmd_buffer_if.sv
// Signal bundle between user logic, the command buffer and the QDR sniffer slave port.
// The buffer sits on the slave modport; the driving side (user + sniffer model) uses master.
interface qdr_cmd_buffer_if #(
    parameter int ADDR_WIDTH         = 32,
    parameter int DATA_WIDTH         = 36,
    parameter int BE_WIDTH           = 4,
    parameter int DEPTH              = 16,
    parameter int MAX_RD_OUTSTANDING = 15
);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int OUT_W = $clog2(MAX_RD_OUTSTANDING + 1);

    logic [ADDR_WIDTH-1:0] usr_addr;
    logic                  usr_wr_en;
    logic                  usr_rd_en;
    logic [DATA_WIDTH-1:0] usr_wr_data;
    logic [BE_WIDTH-1:0]   usr_wr_be;
    logic                  usr_rdy;
    logic [DATA_WIDTH-1:0] usr_rd_data;
    logic                  usr_rd_dvld;
    logic [ADDR_WIDTH-1:0] slave_addr;
    logic                  slave_wr_strb;
    logic [DATA_WIDTH-1:0] slave_wr_data;
    logic [BE_WIDTH-1:0]   slave_wr_be;
    logic                  slave_rd_strb;
    logic [DATA_WIDTH-1:0] slave_rd_data;
    logic                  slave_rd_dvld;
    logic                  slave_ack;
    logic                  phy_rdy;
    logic [LVL_W-1:0]      fifo_level;
    logic [OUT_W-1:0]      rd_outstanding;
    logic [2:0]            err_flags;
    logic [1:0]            state_dbg;

    // Handshake: a command is taken on a clock edge where usr_rdy & (usr_wr_en | usr_rd_en);
    // a strobed command is retired on the edge where slave_ack is high (or on timeout).
    modport slave (
        input  usr_addr, usr_wr_en, usr_rd_en, usr_wr_data, usr_wr_be,
        input  slave_rd_data, slave_rd_dvld, slave_ack, phy_rdy,
        output usr_rdy, usr_rd_data, usr_rd_dvld,
        output slave_addr, slave_wr_strb, slave_wr_data, slave_wr_be, slave_rd_strb,
        output fifo_level, rd_outstanding, err_flags, state_dbg
    );

    modport master (
        output usr_addr, usr_wr_en, usr_rd_en, usr_wr_data, usr_wr_be,
        output slave_rd_data, slave_rd_dvld, slave_ack, phy_rdy,
        input  usr_rdy, usr_rd_data, usr_rd_dvld,
        input  slave_addr, slave_wr_strb, slave_wr_data, slave_wr_be, slave_rd_strb,
        input  fifo_level, rd_outstanding, err_flags, state_dbg
    );
endinterface

// File: rtl/qdr_cmd_buffer.sv
// Command FIFO in front of the QDR sniffer slave port: issues one command at a time,
// waits for ack (with timeout), tracks outstanding reads and returns read data.
module qdr_cmd_buffer #(
    parameter int ADDR_WIDTH         = 32,
    parameter int DATA_WIDTH         = 36,
    parameter int BE_WIDTH           = 4,
    parameter int DEPTH              = 16,
    parameter int MAX_RD_OUTSTANDING = 15,
    parameter int ACK_TIMEOUT        = 255
) (
    input logic             qdr_clk,
    input logic             qdr_reset,
    qdr_cmd_buffer_if.slave bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int OUT_W   = $clog2(MAX_RD_OUTSTANDING + 1);
    localparam int TO_W    = $clog2(ACK_TIMEOUT + 1);
    localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH + BE_WIDTH;

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [OUT_W-1:0] MAX_OUT  = OUT_W'(MAX_RD_OUTSTANDING);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [LVL_W-1:0]      level, level_next;
    logic                  rdy_q;
    logic [OUT_W-1:0]      outstanding;
    logic [TO_W-1:0]       to_cnt;
    logic [2:0]            err_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_dvld_q;

    logic                  push, pop, timeout, rd_ack, active;
    logic                  head_wr;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic [BE_WIDTH-1:0]   head_be;

    assign {head_wr, head_addr, head_data, head_be} = mem[rd_ptr];

    // usr_rdy already guarantees the FIFO is not full, so a push never overwrites.
    assign push   = rdy_q & (bus.usr_wr_en | bus.usr_rd_en);
    assign active = (state == ISSUE) || (state == WAIT_ACK);
    assign rd_ack = active & bus.slave_ack & ~head_wr;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if ((level != '0) && bus.phy_rdy && (head_wr || (outstanding < MAX_OUT)))
                    state_next = ISSUE;
            end
            ISSUE: begin
                if (bus.slave_ack) begin
                    pop        = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.slave_ack) begin
                    pop        = 1'b1;
                    state_next = IDLE;
                end else if (to_cnt == TO_LAST) begin
                    pop        = 1'b1;
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge qdr_clk) begin
        if (push)
            mem[wr_ptr] <= {bus.usr_wr_en, bus.usr_addr, bus.usr_wr_data, bus.usr_wr_be};
    end

    always_ff @(posedge qdr_clk or posedge qdr_reset) begin
        if (qdr_reset) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            rdy_q  <= 1'b0;
            to_cnt <= '0;
        end else begin
            state  <= state_next;
            level  <= level_next;
            rdy_q  <= (level_next != FULL_LVL);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            to_cnt <= (state == WAIT_ACK) ? to_cnt + 1'b1 : '0;
        end
    end

    // Outstanding reads: a dvld with nothing in flight is an error and leaves the count alone.
    always_ff @(posedge qdr_clk or posedge qdr_reset) begin
        if (qdr_reset) begin
            outstanding <= '0;
            err_q       <= '0;
            rd_data_q   <= '0;
            rd_dvld_q   <= 1'b0;
        end else begin
            if (rd_ack && !bus.slave_rd_dvld)
                outstanding <= outstanding + 1'b1;
            else if (!rd_ack && bus.slave_rd_dvld && (outstanding != '0))
                outstanding <= outstanding - 1'b1;
            if (rdy_q && bus.usr_wr_en && bus.usr_rd_en) err_q[0] <= 1'b1;
            if (timeout)                                  err_q[1] <= 1'b1;
            if (bus.slave_rd_dvld && (outstanding == '0)) err_q[2] <= 1'b1;
            rd_data_q <= bus.slave_rd_data;
            rd_dvld_q <= bus.slave_rd_dvld;
        end
    end

    assign bus.usr_rdy        = rdy_q;
    assign bus.usr_rd_data    = rd_data_q;
    assign bus.usr_rd_dvld    = rd_dvld_q;
    assign bus.slave_addr     = active ? head_addr : '0;
    assign bus.slave_wr_data  = active ? head_data : '0;
    assign bus.slave_wr_be    = active ? head_be : '0;
    assign bus.slave_wr_strb  = (state == ISSUE) & head_wr;
    assign bus.slave_rd_strb  = (state == ISSUE) & ~head_wr;
    assign bus.fifo_level     = level;
    assign bus.rd_outstanding = outstanding;
    assign bus.err_flags      = err_q;
    assign bus.state_dbg      = state;
endmodule

// File: tb/tb_qdr_cmd_buffer.sv
// Directed bench for qdr_cmd_buffer: inputs driven and outputs checked on the falling edge.
module tb_qdr_cmd_buffer;
  localparam int AW = 32;
  localparam int DW = 36;
  localparam int BW = 4;
  localparam int DEPTH = 16;
  localparam int MAX_OUT = 15;
  localparam int TMO = 255;

  logic qdr_clk;
  logic qdr_reset;
  int errors;
  int checks;
  logic [AW-1:0] exp_q[$];

  qdr_cmd_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
                      .DEPTH(DEPTH), .MAX_RD_OUTSTANDING(MAX_OUT)) bus ();

  qdr_cmd_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .DEPTH(DEPTH),
                   .MAX_RD_OUTSTANDING(MAX_OUT), .ACK_TIMEOUT(TMO)) dut (
    .qdr_clk(qdr_clk),
    .qdr_reset(qdr_reset),
    .bus(bus)
  );

  // clock / reset
  initial qdr_clk = 1'b0;
  always #5 qdr_clk = ~qdr_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // driver tasks
  task automatic tick();
    @(posedge qdr_clk);
    @(negedge qdr_clk);
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.usr_addr = '0;
    bus.usr_wr_en = 1'b0;
    bus.usr_rd_en = 1'b0;
    bus.usr_wr_data = '0;
    bus.usr_wr_be = '0;
    bus.slave_rd_data = '0;
    bus.slave_rd_dvld = 1'b0;
    bus.slave_ack = 1'b0;
    bus.phy_rdy = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy"}, 64'(bus.usr_rdy), 64'(0));
    check({tag, "_strb"}, 64'({bus.slave_wr_strb, bus.slave_rd_strb}), 64'(0));
    check({tag, "_addr"}, 64'(bus.slave_addr), 64'(0));
    check({tag, "_wdata"}, 64'(bus.slave_wr_data), 64'(0));
    check({tag, "_level"}, 64'(bus.fifo_level), 64'(0));
    check({tag, "_out"}, 64'(bus.rd_outstanding), 64'(0));
    check({tag, "_err"}, 64'(bus.err_flags), 64'(0));
    check({tag, "_state"}, 64'(bus.state_dbg), 64'(0));
  endtask

  initial begin
    int nstrb;
    int last_cyc;
    int wait_cnt;
    logic found;
    logic [AW-1:0] ea;

    errors = 0;
    checks = 0;
    clear_inputs();
    qdr_reset = 1'b1;
    repeat (3) @(negedge qdr_clk);
    check_all_zero("reset");
    qdr_reset = 1'b0;
    tick();
    check("rdy_after_release", 64'(bus.usr_rdy), 64'(1));

    // single write, acked in ISSUE
    bus.phy_rdy = 1'b1;
    bus.usr_addr = 32'h100;
    bus.usr_wr_data = 36'h9_DEAD_BEEF;
    bus.usr_wr_be = 4'hF;
    bus.usr_wr_en = 1'b1;
    tick();
    bus.usr_wr_en = 1'b0;
    bus.slave_ack = 1'b1;
    check("wr_level1", 64'(bus.fifo_level), 64'(1));
    check("wr_nostrb_idle", 64'(bus.slave_wr_strb), 64'(0));
    tick();
    check("wr_strb", 64'(bus.slave_wr_strb), 64'(1));
    check("wr_rdstrb", 64'(bus.slave_rd_strb), 64'(0));
    check("wr_addr", 64'(bus.slave_addr), 64'h100);
    check("wr_data", 64'(bus.slave_wr_data), 64'h9_DEAD_BEEF);
    check("wr_be", 64'(bus.slave_wr_be), 64'hF);
    tick();
    check("wr_strb_once", 64'(bus.slave_wr_strb), 64'(0));
    check("wr_level0", 64'(bus.fifo_level), 64'(0));
    check("wr_rdy", 64'(bus.usr_rdy), 64'(1));
    bus.slave_ack = 1'b0;

    // fill the FIFO with phy_rdy low, then drain with ack tied high
    bus.phy_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.usr_addr = 32'h200 + 32'(i * 4);
      bus.usr_wr_data = 36'(i);
      bus.usr_wr_en = 1'b1;
      exp_q.push_back(32'h200 + 32'(i * 4));
      tick();
    end
    check("full_rdy", 64'(bus.usr_rdy), 64'(0));
    check("full_level", 64'(bus.fifo_level), 64'(16));
    bus.usr_addr = 32'hFFF;
    tick();
    bus.usr_wr_en = 1'b0;
    check("full_ignored", 64'(bus.fifo_level), 64'(16));
    check("full_no_issue", 64'(bus.state_dbg), 64'(0));
    bus.slave_ack = 1'b1;
    bus.phy_rdy = 1'b1;
    nstrb = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      if (bus.slave_wr_strb) begin
        if (exp_q.size() == 0) begin
          check("drain_extra_strobe", 64'(bus.slave_addr), 64'(0));
        end else begin
          ea = exp_q.pop_front();
          check("drain_addr", 64'(bus.slave_addr), 64'(ea));
        end
        if (nstrb > 0) check("drain_gap", 64'(cyc - last_cyc), 64'(2));
        last_cyc = cyc;
        nstrb++;
      end
    end
    check("drain_count", 64'(nstrb), 64'(16));
    check("drain_level", 64'(bus.fifo_level), 64'(0));
    bus.slave_ack = 1'b0;

    // one read, acked in the third WAIT_ACK cycle, data 10 cycles later
    bus.usr_addr = 32'h20;
    bus.usr_rd_en = 1'b1;
    tick();
    bus.usr_rd_en = 1'b0;
    tick();
    check("rd_strb", 64'(bus.slave_rd_strb), 64'(1));
    check("rd_addr", 64'(bus.slave_addr), 64'h20);
    for (int w = 1; w <= 3; w++) begin
      tick();
      check("rd_wait_state", 64'(bus.state_dbg), 64'(2));
      check("rd_wait_nostrb", 64'(bus.slave_rd_strb), 64'(0));
      check("rd_wait_addr", 64'(bus.slave_addr), 64'h20);
    end
    bus.slave_ack = 1'b1;
    tick();
    bus.slave_ack = 1'b0;
    check("rd_out1", 64'(bus.rd_outstanding), 64'(1));
    check("rd_idle", 64'(bus.state_dbg), 64'(0));
    repeat (9) tick();
    check("rd_no_early_dvld", 64'(bus.usr_rd_dvld), 64'(0));
    bus.slave_rd_data = 36'h1234;
    bus.slave_rd_dvld = 1'b1;
    tick();
    bus.slave_rd_dvld = 1'b0;
    check("rd_dvld", 64'(bus.usr_rd_dvld), 64'(1));
    check("rd_data", 64'(bus.usr_rd_data), 64'h1234);
    check("rd_out0", 64'(bus.rd_outstanding), 64'(0));
    tick();
    check("rd_dvld_once", 64'(bus.usr_rd_dvld), 64'(0));

    // outstanding limit: 15 reads acked, 16th held until a dvld
    bus.slave_ack = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.usr_addr = 32'h300 + 32'(i);
      bus.usr_rd_en = 1'b1;
      tick();
    end
    bus.usr_rd_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.rd_outstanding == 4'(MAX_OUT)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("lim_reached", 64'(found), 64'(1));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("lim_no_strb", 64'(bus.slave_rd_strb), 64'(0));
    end
    check("lim_level", 64'(bus.fifo_level), 64'(1));
    check("lim_idle", 64'(bus.state_dbg), 64'(0));
    bus.slave_rd_dvld = 1'b1;
    tick();
    bus.slave_rd_dvld = 1'b0;
    check("lim_out14", 64'(bus.rd_outstanding), 64'(14));
    tick();
    check("lim_issue", 64'(bus.slave_rd_strb), 64'(1));
    check("lim_addr", 64'(bus.slave_addr), 64'h30F);
    tick();
    check("lim_out15", 64'(bus.rd_outstanding), 64'(15));
    bus.slave_ack = 1'b0;
    bus.slave_rd_dvld = 1'b1;
    repeat (15) tick();
    bus.slave_rd_dvld = 1'b0;
    check("lim_drained", 64'(bus.rd_outstanding), 64'(0));
    check("lim_err", 64'(bus.err_flags), 64'(0));

    // ack timeout: first write dropped after 255 WAIT_ACK cycles, second issues
    bus.usr_wr_en = 1'b1;
    bus.usr_addr = 32'h400;
    tick();
    bus.usr_addr = 32'h404;
    tick();
    bus.usr_wr_en = 1'b0;
    wait_cnt = 0;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.slave_wr_strb && bus.slave_addr == 32'h404) begin
        found = 1'b1;
        break;
      end
      if (bus.state_dbg == 2'd2) wait_cnt++;
      tick();
    end
    check("tmo_next_issued", 64'(found), 64'(1));
    check("tmo_wait_cycles", 64'(wait_cnt), 64'(TMO));
    check("tmo_err", 64'(bus.err_flags), 64'b010);
    check("tmo_out", 64'(bus.rd_outstanding), 64'(0));
    bus.slave_ack = 1'b1;
    tick();
    bus.slave_ack = 1'b0;
    check("tmo_level", 64'(bus.fifo_level), 64'(0));

    // write and read enables together, then reset in WAIT_ACK
    bus.usr_addr = 32'h500;
    bus.usr_wr_en = 1'b1;
    bus.usr_rd_en = 1'b1;
    tick();
    bus.usr_wr_en = 1'b0;
    bus.usr_rd_en = 1'b0;
    check("both_level", 64'(bus.fifo_level), 64'(1));
    check("both_err", 64'(bus.err_flags), 64'b011);
    tick();
    check("both_wr_strb", 64'(bus.slave_wr_strb), 64'(1));
    check("both_rd_strb", 64'(bus.slave_rd_strb), 64'(0));
    tick();
    check("both_wait", 64'(bus.state_dbg), 64'(2));
    qdr_reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge qdr_clk);
    qdr_reset = 1'b0;
    tick();
    check("post_rst_rdy", 64'(bus.usr_rdy), 64'(1));
    check("post_rst_level", 64'(bus.fifo_level), 64'(0));
    bus.slave_rd_data = 36'h77;
    bus.slave_rd_dvld = 1'b1;
    tick();
    bus.slave_rd_dvld = 1'b0;
    check("stray_dvld", 64'(bus.usr_rd_dvld), 64'(1));
    check("stray_data", 64'(bus.usr_rd_data), 64'h77);
    check("stray_err", 64'(bus.err_flags), 64'b100);
    check("stray_out", 64'(bus.rd_outstanding), 64'(0));

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
